// File: rtl/ps2_host_tx_if.sv
// Command handshake between the PS/2 host transmitter and its client logic.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first,
// odd parity and stop on device clock falls, then device ACK check.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe,
    ps2_host_tx_if.slave   tx
);

    localparam int unsigned TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned BW   = 4;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    clk_sync_q, data_sync_q;
    logic [9:0]    shift_q, shift_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ack_ok_q, ack_ok_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          fall_c;
    logic          data_s_c;
    logic          bus_idle_c;
    logic          timeout_c;

    // Three-stage synchronizers for the asynchronous PS/2 lines.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
        end
    end

    assign fall_c     = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s_c   = data_sync_q[2];
    assign bus_idle_c = clk_sync_q[1] & data_s_c;
    assign timeout_c  = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // State and registered-output flops.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            timer_q   <= '0;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            timer_q   <= timer_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        timer_d   = timer_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx.tx_valid) begin
                    shift_d  = {1'b1, ~^tx.tx_data, tx.tx_data};
                    bitcnt_d = '0;
                    timer_d  = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    timer_d   = '0;
                    state_d   = START;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            START: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
                bitcnt_d  = '0;
                timer_d   = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (fall_c) begin
                    data_oe_d = ~shift_q[bitcnt_q];
                    bitcnt_d  = bitcnt_q + BW'(1);
                    timer_d   = '0;
                    if (bitcnt_q == BW'(9)) begin
                        state_d = ACK;
                    end
                end else if (timeout_c) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timer_d   = '0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ACK: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (fall_c) begin
                    ack_ok_d = ~data_s_c;
                    timer_d  = '0;
                    state_d  = WAIT_IDLE;
                end else if (timeout_c) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (bus_idle_c) begin
                    timer_d = '0;
                    done_d  = ack_ok_q;
                    err_d   = ~ack_ok_q;
                    state_d = IDLE;
                end else if (timeout_c) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                timer_d   = '0;
                state_d   = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx.tx_ready = ready_q;
    assign tx.tx_busy  = busy_q;
    assign tx.tx_done  = done_q;
    assign tx.tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard-side clock/ACK model on an open-drain bus
// and a byte-level frame reference model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 8;
    localparam int unsigned TMO  = 200;
    localparam int unsigned HALF = 20;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_line, ps2_data_line;
    logic ps2_clk_oe, ps2_data_oe;

    // Wired-AND open-drain bus with pull-ups.
    assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk_line),
        .ps2_data    (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx          (tx_if)
    );

    int errors = 0;
    int checks = 0;

    int cyc         = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int overlap_cnt = 0;
    int oe_run      = 0;
    int last_run    = 0;
    logic run_last_data  = 1'b0;
    logic last_run_data  = 1'b0;

    logic [9:0] got_bits;
    logic       got_start;
    int         last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and inhibit-window length monitor.
    always @(negedge clk) begin
        if (tx_if.tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_if.tx_err === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_if.tx_done === 1'b1 && tx_if.tx_err === 1'b1) overlap_cnt <= overlap_cnt + 1;
        if (ps2_clk_oe === 1'b1) begin
            oe_run        <= oe_run + 1;
            run_last_data <= ps2_data_oe;
        end else if (oe_run != 0) begin
            last_run      <= oe_run;
            last_run_data <= run_last_data;
            oe_run        <= 0;
        end
    end

    // Reference frame: data LSB first, odd parity, stop bit.
    function automatic logic [9:0] expect_frame(input logic [7:0] b);
        int ones = 0;
        logic [9:0] f;
        for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i] = b[i];
        end
        f[8] = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic wait_clk_oe(input logic lvl, input string tag);
        int n = 0;
        while (ps2_clk_oe !== lvl && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk_oe !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: ps2_clk_oe=%b never reached %b", tag, ps2_clk_oe, lvl);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (tx_if.tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (tx_if.tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: tx_ready=%b never returned to 1", tag, tx_if.tx_ready);
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        tx_if.tx_data  = b;
        tx_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_if.tx_valid = 1'b0;
    endtask

    // Keyboard model: clocks nfalls falls, samples the host bit at the end of
    // each low phase, optionally ACKs, optionally pulls clrn at fall abort_at.
    task automatic dev_frame(input int nfalls, input bit ack, input int abort_at);
        got_bits  = '0;
        got_start = 1'bx;
        wait_clk_oe(1'b1, "inhibit_start");
        wait_clk_oe(1'b0, "inhibit_end");
        got_start = ps2_data_line;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            if (k == abort_at) begin
                clrn = 1'b0;
                #1;
                checks++;
                if (ps2_clk_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_clk_oe: got %b want 0", ps2_clk_oe);
                end
                checks++;
                if (ps2_data_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_data_oe: got %b want 0", ps2_data_oe);
                end
                repeat (5) @(negedge clk);
                clrn        = 1'b1;
                dev_clk_low = 1'b0;
                return;
            end
            repeat (HALF) @(negedge clk);
            if (k <= 10) got_bits[k-1] = ps2_data_line;
            dev_clk_low = 1'b0;
            if (k == 10 && ack) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic test_reset;
        clrn = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        checks++;
        if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
        checks++;
        if (tx_if.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_if.tx_ready); end
        checks++;
        if (tx_if.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_if.tx_busy); end
        checks++;
        if (tx_if.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_if.tx_done); end
        checks++;
        if (tx_if.tx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", tx_if.tx_err); end
        clrn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send_ed;
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [9:0] exp_f = expect_frame(8'hED);
        @(negedge clk);
        checks++;
        if (tx_if.tx_ready !== 1'b1) begin errors++; $display("FAIL ed_ready_before: got %b want 1", tx_if.tx_ready); end
        tx_if.tx_data  = 8'hED;
        tx_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_if.tx_valid = 1'b0;
        checks++;
        if (tx_if.tx_ready !== 1'b0) begin errors++; $display("FAIL ed_ready_after_accept: got %b want 0", tx_if.tx_ready); end
        checks++;
        if (ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL ed_clk_oe_after_accept: got %b want 1", ps2_clk_oe); end
        checks++;
        if (tx_if.tx_busy !== 1'b1) begin errors++; $display("FAIL ed_busy: got %b want 1", tx_if.tx_busy); end
        dev_frame(11, 1'b1, 0);
        wait_ready("ed_ready");
        repeat (2) @(negedge clk);
        checks++;
        if (last_run != int'(INH + 1)) begin errors++; $display("FAIL ed_inhibit_len: got %0d want %0d", last_run, INH + 1); end
        checks++;
        if (last_run_data !== 1'b1) begin errors++; $display("FAIL ed_start_overlap: data_oe in last inhibit cycle %b want 1", last_run_data); end
        checks++;
        if (got_start !== 1'b0) begin errors++; $display("FAIL ed_start_bit: got %b want 0", got_start); end
        checks++;
        if (got_bits !== 10'b11_1110_1101) begin errors++; $display("FAIL ed_bits: got %b want %b", got_bits, 10'b11_1110_1101); end
        checks++;
        if (got_bits !== exp_f) begin errors++; $display("FAIL ed_model: got %b want %b", got_bits, exp_f); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL ed_done: got %0d pulses want 1", done_cnt - d0); end
        checks++;
        if (err_cnt - e0 != 0) begin errors++; $display("FAIL ed_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_parity;
        logic [7:0] bytes [6];
        logic       par   [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h01;
        par[0] = 1'b1; par[1] = 1'b1; par[2] = 1'b0;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            int d0 = done_cnt;
            logic [9:0] exp_f = expect_frame(bytes[i]);
            start_tx(bytes[i]);
            dev_frame(11, 1'b1, 0);
            wait_ready("parity_ready");
            repeat (2) @(negedge clk);
            checks++;
            if (got_bits !== exp_f) begin errors++; $display("FAIL parity_frame[%0d] byte %h: got %b want %b", i, bytes[i], got_bits, exp_f); end
            if (i < 3) begin
                checks++;
                if (got_bits[8] !== par[i]) begin errors++; $display("FAIL parity_bit[%0d]: got %b want %b", i, got_bits[8], par[i]); end
            end
            checks++;
            if (done_cnt - d0 != 1) begin errors++; $display("FAIL parity_done[%0d]: got %0d want 1", i, done_cnt - d0); end
        end
    endtask

    task automatic test_nack;
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [7:0] b = 8'($urandom);
        logic [9:0] exp_f = expect_frame(b);
        start_tx(b);
        dev_frame(11, 1'b0, 0);
        wait_ready("nack_ready");
        repeat (2) @(negedge clk);
        checks++;
        if (got_bits !== exp_f) begin errors++; $display("FAIL nack_frame: got %b want %b", got_bits, exp_f); end
        checks++;
        if (err_cnt - e0 != 1) begin errors++; $display("FAIL nack_err: got %0d want 1", err_cnt - e0); end
        checks++;
        if (done_cnt - d0 != 0) begin errors++; $display("FAIL nack_done: got %0d want 0", done_cnt - d0); end
        checks++;
        if (tx_if.tx_ready !== 1'b1) begin errors++; $display("FAIL nack_ready: got %b want 1", tx_if.tx_ready); end
    endtask

    task automatic test_timeout;
        int d0 = done_cnt;
        int e0 = err_cnt;
        int n  = 0;
        int dt;
        start_tx(8'($urandom));
        dev_frame(4, 1'b1, 0);
        checks++;
        if (tx_if.tx_busy !== 1'b1) begin errors++; $display("FAIL timeout_early: busy %b want 1", tx_if.tx_busy); end
        while (tx_if.tx_busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        dt = cyc - last_fall_cyc;
        checks++;
        if (dt < int'(TMO) || dt > int'(TMO) + 5) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d..%0d", dt, TMO, TMO + 5); end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL timeout_oe: got %b%b want 00", ps2_clk_oe, ps2_data_oe); end
        repeat (2) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); end
        checks++;
        if (done_cnt - d0 != 0) begin errors++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
        checks++;
        if (tx_if.tx_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b want 1", tx_if.tx_ready); end
    endtask

    task automatic test_back_to_back;
        int d0 = done_cnt;
        int n  = 0;
        logic [7:0] b1 = 8'($urandom);
        if (b1 == 8'h55) b1 = 8'hA3;
        @(negedge clk);
        tx_if.tx_data  = b1;
        tx_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_if.tx_data = 8'h55;
        dev_frame(11, 1'b1, 0);
        checks++;
        if (got_bits !== expect_frame(b1)) begin errors++; $display("FAIL b2b_first: got %b want %b", got_bits, expect_frame(b1)); end
        while (tx_if.tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tx_if.tx_valid = 1'b0;
        checks++;
        if (tx_if.tx_ready !== 1'b0 || tx_if.tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reaccept: ready=%b busy=%b want 0 1", tx_if.tx_ready, tx_if.tx_busy);
        end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_done1: got %0d want 1", done_cnt - d0); end
        dev_frame(11, 1'b1, 0);
        wait_ready("b2b_ready");
        repeat (2) @(negedge clk);
        checks++;
        if (got_bits !== expect_frame(8'h55)) begin errors++; $display("FAIL b2b_second: got %b want %b", got_bits, expect_frame(8'h55)); end
        checks++;
        if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done2: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        int d0, e0;
        start_tx(8'($urandom));
        d0 = done_cnt;
        e0 = err_cnt;
        dev_frame(11, 1'b1, 5);
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            errors++;
            $display("FAIL midreset_pulses: done+%0d err+%0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (tx_if.tx_ready !== 1'b1 || tx_if.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: ready=%b busy=%b want 1 0", tx_if.tx_ready, tx_if.tx_busy);
        end
        d0 = done_cnt;
        start_tx(8'hF4);
        dev_frame(11, 1'b1, 0);
        wait_ready("f4_ready");
        repeat (2) @(negedge clk);
        checks++;
        if (got_bits !== expect_frame(8'hF4)) begin errors++; $display("FAIL f4_frame: got %b want %b", got_bits, expect_frame(8'hF4)); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL f4_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_exclusive;
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL done_err_overlap: got %0d cycles want 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain ps2_clk/ps2_data pair the existing ps2_keyboard receiver listens on. It runs the request-to-send sequence, shifts out data, odd parity and stop bits on device-generated clock falling edges, and checks the device acknowledge. It sits beside ps2_keyboard under top. tx_busy lets downstream logic ignore receiver activity while a host frame is on the wire.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 100000: maximum clk cycles between consecutive device clock falling edges, and the maximum wait for the bus to go idle.
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  PS/2 clock line as sensed (asynchronous).
- ps2_data  in  1  PS/2 data line as sensed (asynchronous).
- ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release.
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release.
- tx_data  in  8  byte to send.
- tx_valid  in  1  send request.
- tx_ready  out  1  1 while in IDLE; the byte is accepted when tx_valid & tx_ready.
- tx_busy  out  1  1 in every state except IDLE.
- tx_done  out  1  one-cycle pulse: frame sent and ACK received.
- tx_err  out  1  one-cycle pulse: NACK or timeout.

## Operation
- The block synchronizes ps2_clk and ps2_data through 3-flop shift registers, the same structure as ps2_keyboard.
- A falling edge (fall) is decoded when the two oldest clock samples read 1 then 0.
- On accept, the block latches shift = {1'b1 stop, ~^tx_data odd parity, tx_data}, clears bitcnt and clears the timer.
- States and transitions:
  - IDLE: both oe = 0. On accept, go to INHIBIT.
  - INHIBIT: clk_oe = 1, data_oe = 0. After INHIBIT_CYCLES cycles, go to START.
  - START: one cycle with clk_oe = 1 and data_oe = 1, then go to SEND.
  - SEND: clk_oe = 0. data_oe starts at 1 (start bit). On each fall, data_oe <= ~shift[bitcnt], bitcnt + 1. The fall that presents bitcnt = 9 releases data (stop bit) and moves the block to ACK. Data bits go out LSB first.
  - ACK: both oe = 0. On the next fall, ack_ok <= (synced ps2_data == 0). Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced ps2_clk and ps2_data are both 1. Then go to IDLE, pulsing tx_done if ack_ok, else tx_err.
- Timeout: the timer counts in SEND, ACK and WAIT_IDLE, and clears on every fall and on every state entry. If it reaches TIMEOUT_CYCLES, the block sets both oe to 0 the next cycle, goes to IDLE and pulses tx_err.
- tx_valid while busy is ignored; there is no queue.
- tx_done and tx_err never assert in the same cycle.
- The block never drives either line high (open-drain only).

## Timing
- Reset values: state IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, tx_busy = 0, tx_done = 0, tx_err = 0, bitcnt = 0, timer = 0.
- Reset is asynchronous. Asserting clrn mid-frame releases both lines immediately and no tx_done or tx_err pulse is produced.
- All outputs are registered.
- Accept cycle t: tx_ready = 0 and clk_oe = 1 from t+1.
- clk_oe is high for INHIBIT_CYCLES + 1 cycles; data_oe rises in the final one.
- Each data_oe change lands 3 clk cycles after the physical ps2_clk fall (2 sync + 1 register). This is well inside the device's ~30 us low phase.
- The frame takes 11 falls: falls 1–8 present D0–D7, fall 9 presents parity, fall 10 releases (stop), fall 11 samples ACK.
- tx_done / tx_err fires in the cycle IDLE is re-entered; tx_ready = 1 in that same cycle.

## Test plan
- Send 0xED (INHIBIT_CYCLES = 8), keyboard model clocking at a 40-cycle period:
  - clk_oe high for exactly 9 cycles.
  - Line values at falls 1–10: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Model ACKs low → one tx_done pulse; tx_err stays 0.
- Parity sweep (0x00, 0xFF, 0x01) → parity bits 1, 1, 0; all complete with tx_done.
- NACK: model leaves data high at fall 11 → tx_err pulse, no tx_done, tx_ready returns to 1.
- Timeout (TIMEOUT_CYCLES = 200): model stops clocking after fall 4 → 200 cycles later both oe = 0, one tx_err pulse, state IDLE.
- tx_valid held with new data (0x55) during a busy frame → ignored; the wire shows only the first byte. A new accept succeeds only in the cycle tx_ready = 1.
- Pull clrn low at fall 5, then release → both oe = 0 immediately, no done/err pulse. A subsequent send of 0xF4 completes normally.
